// File: rtl/serial_subtractor.sv
// ============================================================================
// serial_subtractor : bit-serial N-bit subtractor, diff = a - b - bin, LSB first
// Rev 1.0
// ============================================================================
`default_nettype none

module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout,
  output logic             ovf
);

  localparam int            CW   = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state, state_n;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] a_sr, b_sr, res_sr;
  logic             brw;
  logic             d, nb;

  // Single full-subtractor cell working on the current LSBs
  always_comb begin
    d  = a_sr[0] ^ b_sr[0] ^ brw;
    nb = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & brw);
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (start) state_n = RUN;
      RUN:     if (count == LAST) state_n = DONE;
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      count  <= '0;
      a_sr   <= '0;
      b_sr   <= '0;
      res_sr <= '0;
      brw    <= 1'b0;
      ready  <= 1'b1;
      done   <= 1'b0;
      diff   <= '0;
      bout   <= 1'b0;
      ovf    <= 1'b0;
    end else begin
      state <= state_n;
      ready <= (state_n == IDLE);
      done  <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a_sr  <= a;
            b_sr  <= b;
            brw   <= bin;
            count <= '0;
          end
        end
        RUN: begin
          a_sr   <= a_sr >> 1;
          b_sr   <= b_sr >> 1;
          res_sr <= {d, res_sr[WIDTH-1:1]};
          brw    <= nb;
          count  <= count + CW'(1);
          // Last bit: brw is still the borrow into the MSB, nb the borrow out
          if (count == LAST) begin
            diff <= {d, res_sr[WIDTH-1:1]};
            bout <= nb;
            ovf  <= brw ^ nb;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// tb_serial_subtractor : directed and exhaustive checks of serial_subtractor
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  logic       start8, bin8, ready8, done8, bout8, ovf8;
  logic [7:0] a8, b8, diff8;
  logic       start5, bin5, ready5, done5, bout5, ovf5;
  logic [4:0] a5, b5, diff5;
  logic       start2, bin2, ready2, done2, bout2, ovf2;
  logic [1:0] a2, b2, diff2;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .rst(rst), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .ready(ready8), .done(done8), .diff(diff8), .bout(bout8), .ovf(ovf8));

  serial_subtractor #(.WIDTH(5)) u_dut5 (
    .clk(clk), .rst(rst), .start(start5), .a(a5), .b(b5), .bin(bin5),
    .ready(ready5), .done(done5), .diff(diff5), .bout(bout5), .ovf(ovf5));

  serial_subtractor #(.WIDTH(2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .bin(bin2),
    .ready(ready2), .done(done2), .diff(diff2), .bout(bout2), .ovf(ovf2));

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference {diff, bout, ovf} for a w-bit subtract, from integer arithmetic
  function automatic logic [63:0] ref_sub(input int w, input int a, input int b, input int bi);
    int half, r, sa, sb;
    logic [63:0] dv;
    half = 1 << (w - 1);
    dv   = 64'((a - b - bi) & ((1 << w) - 1));
    sa   = (a >= half) ? a - 2 * half : a;
    sb   = (b >= half) ? b - 2 * half : b;
    r    = sa - sb - bi;
    return (dv << 2) | (64'(a < b + bi) << 1) | 64'((r < -half) || (r >= half));
  endfunction

  // Full WIDTH=8 op from an IDLE negedge; ends at the negedge after DONE
  task automatic op8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic bi,
                     input logic [7:0] ed, input logic eb, input logic eo);
    int lat;
    check({tag, " ready"}, 64'(ready8), 64'd1);
    start8 = 1'b1; a8 = a; b8 = b; bin8 = bi;
    @(negedge clk);
    start8 = 1'b0; a8 = ~a; b8 = ~b; bin8 = ~bi;
    lat = 1;
    check({tag, " busy"}, 64'(ready8), 64'd0);
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, " latency"}, 64'(lat), 64'd9);
    check({tag, " diff"}, 64'(diff8), 64'(ed));
    check({tag, " bout"}, 64'(bout8), 64'(eb));
    check({tag, " ovf"},  64'(ovf8),  64'(eo));
    @(negedge clk);
    check({tag, " pulse"}, 64'({done8, ready8}), 64'b01);
  endtask

  task automatic op5(input int a, input int b, input int bi);
    int lat;
    start5 = 1'b1; a5 = 5'(a); b5 = 5'(b); bin5 = bi[0];
    @(negedge clk);
    start5 = 1'b0;
    lat = 1;
    while (!done5 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("w5 latency", 64'(lat), 64'd6);
    check("w5 result", 64'({diff5, bout5, ovf5}), ref_sub(5, a, b, bi));
    @(negedge clk);
  endtask

  task automatic op2(input int a, input int b, input int bi);
    int lat;
    start2 = 1'b1; a2 = 2'(a); b2 = 2'(b); bin2 = bi[0];
    @(negedge clk);
    start2 = 1'b0;
    lat = 1;
    while (!done2 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("w2 latency", 64'(lat), 64'd3);
    check("w2 result", 64'({diff2, bout2, ovf2}), ref_sub(2, a, b, bi));
    @(negedge clk);
  endtask

  initial begin
    int lat;
    bit seen;
    rst = 1'b1;
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'h01; bin8 = 1'b1;
    start5 = 1'b0; a5 = '0; b5 = '0; bin5 = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; bin2 = 1'b0;

    // Reset held two edges with start high
    repeat (2) @(negedge clk);
    check("reset outs", 64'({ready8, done8, diff8, bout8, ovf8}), 64'({1'b1, 1'b0, 8'h00, 1'b0, 1'b0}));
    rst = 1'b0; start8 = 1'b0;
    seen = 1'b0;
    repeat (10) begin
      @(negedge clk);
      if (done8 || !ready8) seen = 1'b1;
    end
    check("reset no op", 64'(seen), 64'd0);

    op8("t2 5-3",   8'h05, 8'h03, 1'b0, 8'h02, 1'b0, 1'b0);
    op8("t3 3-5",   8'h03, 8'h05, 1'b0, 8'hFE, 1'b1, 1'b0);
    op8("t3 0-0-1", 8'h00, 8'h00, 1'b1, 8'hFF, 1'b1, 1'b0);
    op8("t4 80-1",  8'h80, 8'h01, 1'b0, 8'h7F, 1'b0, 1'b1);
    op8("t4 7F-FF", 8'h7F, 8'hFF, 1'b0, 8'h80, 1'b1, 1'b1);

    // Starts during RUN and DONE must be ignored
    start8 = 1'b1; a8 = 8'h10; b8 = 8'h01; bin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    @(negedge clk);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    @(negedge clk);
    start8 = 1'b0;
    lat = 3;
    while (!done8 && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check("t5 latency", 64'(lat), 64'd9);
    check("t5 diff", 64'(diff8), 64'h0F);
    start8 = 1'b1; a8 = 8'hAA; b8 = 8'h55;
    @(negedge clk);
    start8 = 1'b0;
    check("t5 ignored", 64'({ready8, done8}), 64'b10);
    op8("t5 next", 8'hAA, 8'h55, 1'b0, 8'h55, 1'b0, 1'b1);

    // Reset during RUN cycle k=4
    start8 = 1'b1; a8 = 8'h3C; b8 = 8'h11; bin8 = 1'b0;
    @(negedge clk);
    start8 = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t6 reset outs", 64'({ready8, done8, diff8, bout8, ovf8}), 64'({1'b1, 1'b0, 8'h00, 1'b0, 1'b0}));
    seen = 1'b0;
    repeat (12) begin
      @(negedge clk);
      if (done8) seen = 1'b1;
    end
    check("t6 no done", 64'(seen), 64'd0);
    op8("t6 64-32", 8'h64, 8'h32, 1'b0, 8'h32, 1'b0, 1'b0);

    for (int x = 0; x < 4; x++)
      for (int y = 0; y < 4; y++)
        for (int c = 0; c < 2; c++)
          op2(x, y, c);
    for (int x = 0; x < 32; x++)
      for (int y = 0; y < 32; y++)
        for (int c = 0; c < 2; c++)
          op5(x, y, c);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
